// File: rtl/emu_pkg.sv
// ---------------------------------------------------------------------------
// emu_pkg
// Shared definitions for the emulation host sequencer slice.
//   EMU_DATA_W   : byte width on host streams and the wrapper data buses.
//   EMU_ADDR_W   : default Addr_emu width.
//   emu_state_e  : sequencer state encoding (4-bit, legacy-compatible values).
// Build option (preprocessor macro, not a package item):
//   EMU_VEC_CNT_EN : adds the 16-bit completed-vector counter output vec_cnt.
// ---------------------------------------------------------------------------
package emu_pkg;

    localparam int EMU_DATA_W = 8;
    localparam int EMU_ADDR_W = 3;

    typedef enum logic [3:0] {
        EMU_ST_IDLE  = 4'd0,   // accept stimulus bytes (WR)
        EMU_ST_LWAIT = 4'd1,   // let the wrapper store the last byte
        EMU_ST_LOAD  = 4'd2,   // load_emu high
        EMU_ST_CLK   = 4'd3,   // clk_dut pulses in progress (DHI/DLO)
        EMU_ST_GET   = 4'd4,   // get_emu high
        EMU_ST_RADDR = 4'd5,   // present readback index
        EMU_ST_RWAIT = 4'd6,   // wrapper registers Dout_emu
        EMU_ST_RCAP  = 4'd7,   // capture Dout_emu into rsp_data
        EMU_ST_RSP   = 4'd8    // hold response until accepted
    } emu_state_e;

endpackage

// File: rtl/emu_host_sequencer_if.sv
// ---------------------------------------------------------------------------
// emu_host_sequencer_if
// Bundles the host byte streams and the emulation-wrapper bus.
//   cmd_data/cmd_valid/cmd_ready : stimulus byte stream from the host bridge
//   rsp_data/rsp_valid/rsp_ready : output-vector byte stream to the host
//   Din_emu/Addr_emu/load_emu/get_emu/clk_dut/Dout_emu : wrapper bus
// Modports:
//   master : the sequencer (drives cmd_ready, rsp_*, wrapper controls)
//   slave  : host bridge + wrapper side
// ---------------------------------------------------------------------------
interface emu_host_sequencer_if
    import emu_pkg::*;
#(
    parameter int ADDR_W = EMU_ADDR_W
) ();

    logic [EMU_DATA_W-1:0] cmd_data;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [EMU_DATA_W-1:0] rsp_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [EMU_DATA_W-1:0] Din_emu;
    logic [ADDR_W-1:0]     Addr_emu;
    logic                  load_emu;
    logic                  get_emu;
    logic                  clk_dut;
    logic [EMU_DATA_W-1:0] Dout_emu;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready, Dout_emu,
        output cmd_ready, rsp_data, rsp_valid,
        output Din_emu, Addr_emu, load_emu, get_emu, clk_dut
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready, Dout_emu,
        input  cmd_ready, rsp_data, rsp_valid,
        input  Din_emu, Addr_emu, load_emu, get_emu, clk_dut
    );

endinterface

// File: rtl/emu_dut_clkgen.sv
// ---------------------------------------------------------------------------
// emu_dut_clkgen
// Produces DUT_CLKS registered clk_dut pulses after a start strobe. Each pulse
// is one clk_emu cycle high followed by one cycle low. done is a one-cycle
// pulse that coincides with the low phase of the final pulse.
// Ports:
//   clk_emu : emulation clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   start   : begin a pulse train (ignored while busy)
//   clk_dut : DUT clock output, registered
//   done    : one-cycle completion strobe, registered
// ---------------------------------------------------------------------------
module emu_dut_clkgen #(
    parameter int DUT_CLKS = 1
) (
    input  logic clk_emu,
    input  logic rst_n,
    input  logic start,
    output logic clk_dut,
    output logic done
);

    localparam logic [7:0] LAST_PULSE = 8'(DUT_CLKS - 1);

    logic [7:0] remain_reg;
    logic       busy_reg;
    logic       clk_dut_reg;
    logic       done_reg;

    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            remain_reg  <= '0;
            busy_reg    <= 1'b0;
            clk_dut_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (start) begin
                    busy_reg    <= 1'b1;
                    clk_dut_reg <= 1'b1;
                    remain_reg  <= LAST_PULSE;
                end
            end else if (clk_dut_reg) begin
                // Falling half of a pulse; the last one also signals done
                clk_dut_reg <= 1'b0;
                if (remain_reg == 8'd0) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end else begin
                clk_dut_reg <= 1'b1;
                remain_reg  <= remain_reg - 8'd1;
            end
        end
    end

    assign clk_dut = clk_dut_reg;
    assign done    = done_reg;

endmodule

// File: rtl/emu_host_sequencer.sv
// ---------------------------------------------------------------------------
// emu_host_sequencer
// Host-side initiator for the emulation wrapper. Collects NUM_STIM stimulus
// bytes from the host stream into the wrapper, pulses load_emu, runs
// DUT_CLKS clk_dut pulses, pulses get_emu, then streams NUM_OUT output
// bytes back to the host with full backpressure.
// Ports:
//   clk_emu : emulation clock (rising edge)
//   rst_n   : asynchronous active-low reset; aborts any vector in flight
//   bus     : emu_host_sequencer_if.master (host streams + wrapper bus)
//   vec_cnt : completed-vector count, only when EMU_VEC_CNT_EN is defined
// The wrapper writes stimIn[Addr_emu]<=Din_emu and Dout_emu<=vectOut[Addr_emu]
// on every edge where load_emu and get_emu are both low, so Din_emu and
// Addr_emu simply hold between writes.
// ---------------------------------------------------------------------------
module emu_host_sequencer
    import emu_pkg::*;
#(
    parameter int NUM_STIM = 2,
    parameter int NUM_OUT  = 2,
    parameter int ADDR_W   = EMU_ADDR_W,
    parameter int DUT_CLKS = 1
) (
    input  logic                 clk_emu,
    input  logic                 rst_n,
    emu_host_sequencer_if.master bus
`ifdef EMU_VEC_CNT_EN
    ,
    output logic [15:0]          vec_cnt
`endif
);

    localparam logic [3:0] S_IDLE  = EMU_ST_IDLE;
    localparam logic [3:0] S_LWAIT = EMU_ST_LWAIT;
    localparam logic [3:0] S_LOAD  = EMU_ST_LOAD;
    localparam logic [3:0] S_CLK   = EMU_ST_CLK;
    localparam logic [3:0] S_GET   = EMU_ST_GET;
    localparam logic [3:0] S_RADDR = EMU_ST_RADDR;
    localparam logic [3:0] S_RWAIT = EMU_ST_RWAIT;
    localparam logic [3:0] S_RCAP  = EMU_ST_RCAP;
    localparam logic [3:0] S_RSP   = EMU_ST_RSP;

    localparam logic [ADDR_W-1:0] LAST_STIM = ADDR_W'(NUM_STIM - 1);
    localparam logic [ADDR_W-1:0] LAST_OUT  = ADDR_W'(NUM_OUT - 1);

    logic [3:0]            state_reg;
    logic [ADDR_W-1:0]     stim_idx_reg;
    logic [ADDR_W-1:0]     out_idx_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [EMU_DATA_W-1:0] din_reg;
    logic [EMU_DATA_W-1:0] rsp_data_reg;
    logic                  cmd_ready_reg;
    logic                  rsp_valid_reg;
    logic                  load_reg;
    logic                  get_reg;

    logic                  cmd_fire;
    logic                  rsp_fire;
    logic                  last_out;
    logic                  clk_start;
    logic                  clk_done;
    logic                  clk_dut_w;

    assign cmd_fire  = bus.cmd_valid && cmd_ready_reg;
    assign rsp_fire  = rsp_valid_reg && bus.rsp_ready;
    assign last_out  = (out_idx_reg == LAST_OUT);
    // load_emu is high during S_LOAD, so the first clk_dut rise lands on the
    // edge right after the wrapper has copied stimIn into the DUT inputs.
    assign clk_start = (state_reg == S_LOAD);

    emu_dut_clkgen #(
        .DUT_CLKS (DUT_CLKS)
    ) u_clkgen (
        .clk_emu (clk_emu),
        .rst_n   (rst_n),
        .start   (clk_start),
        .clk_dut (clk_dut_w),
        .done    (clk_done)
    );

    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            stim_idx_reg  <= '0;
            out_idx_reg   <= '0;
            addr_reg      <= '0;
            din_reg       <= '0;
            rsp_data_reg  <= '0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            load_reg      <= 1'b0;
            get_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    cmd_ready_reg <= 1'b1;
                    if (cmd_fire) begin
                        din_reg  <= bus.cmd_data;
                        addr_reg <= stim_idx_reg;
                        if (stim_idx_reg == LAST_STIM) begin
                            stim_idx_reg  <= '0;
                            cmd_ready_reg <= 1'b0;
                            state_reg     <= S_LWAIT;
                        end else begin
                            stim_idx_reg <= stim_idx_reg + 1'b1;
                        end
                    end
                end
                S_LWAIT: begin
                    // Wrapper stores the final byte on this edge
                    load_reg  <= 1'b1;
                    state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    load_reg  <= 1'b0;
                    state_reg <= S_CLK;
                end
                S_CLK: begin
                    // done arrives during the last low phase, so get_emu
                    // never overlaps a high clk_dut
                    if (clk_done) begin
                        get_reg   <= 1'b1;
                        state_reg <= S_GET;
                    end
                end
                S_GET: begin
                    get_reg   <= 1'b0;
                    state_reg <= S_RADDR;
                end
                S_RADDR: begin
                    addr_reg  <= out_idx_reg;
                    state_reg <= S_RWAIT;
                end
                S_RWAIT: begin
                    state_reg <= S_RCAP;
                end
                S_RCAP: begin
                    rsp_data_reg  <= bus.Dout_emu;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_fire) begin
                        rsp_valid_reg <= 1'b0;
                        if (last_out) begin
                            out_idx_reg   <= '0;
                            cmd_ready_reg <= 1'b1;
                            state_reg     <= S_IDLE;
                        end else begin
                            out_idx_reg <= out_idx_reg + 1'b1;
                            state_reg   <= S_RADDR;
                        end
                    end
                end
                default: begin
                    cmd_ready_reg <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                    load_reg      <= 1'b0;
                    get_reg       <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef EMU_VEC_CNT_EN
    logic [15:0] vec_cnt_reg;

    // Counts on the edge the final response byte is taken; wraps naturally
    always_ff @(posedge clk_emu or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt_reg <= '0;
        end else if ((state_reg == S_RSP) && rsp_fire && last_out) begin
            vec_cnt_reg <= vec_cnt_reg + 16'd1;
        end
    end

    assign vec_cnt = vec_cnt_reg;
`endif

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.Din_emu   = din_reg;
    assign bus.Addr_emu  = addr_reg;
    assign bus.load_emu  = load_reg;
    assign bus.get_emu   = get_reg;
    assign bus.clk_dut   = clk_dut_w;

endmodule
